// File: rtl/inst_fetch_if.sv
// Instruction-cache request/response bus between the fetch stage and the I-cache.
// ren/addr are driven by fetch; rdata/stall are returned by the cache.
interface inst_fetch_if;
  logic        ren;
  logic [29:0] addr;
  logic [31:0] rdata;
  logic        stall;

  modport master (output ren, output addr, input rdata, input stall);
  modport slave  (input ren, input addr, output rdata, output stall);
endinterface

// File: rtl/inst_fetch.sv
// RV32I instruction-fetch stage: PC, I-cache request FSM, IF/ID register, skid buffer, redirect kill.
// Optional static branch/jump prediction is enabled by defining IF_PREDICT_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  inst_fetch_if.master        icache,
  input  logic                id_stall,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                id_valid,
  output logic [31:0]         id_inst,
  output logic [31:0]         id_pc,
  output logic                id_pred_taken
);
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_SKID} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        id_valid_reg, id_valid_next;
  logic [31:0] id_inst_reg, id_inst_next;
  logic [31:0] id_pc_reg, id_pc_next;
  logic        id_pred_reg, id_pred_next;
  logic [31:0] skid_inst_reg, skid_inst_next;
  logic [31:0] skid_pc_reg, skid_pc_next;
  logic        skid_pred_reg, skid_pred_next;
  logic        kill_reg, kill_next;
  logic [31:0] kill_pc_reg, kill_pc_next;

  logic        ren;
  logic        complete;
  logic        can_accept;
  logic [31:0] redirect_target;
  logic [31:0] next_pc;
  logic        pred_taken;

  assign redirect_target = redirect_pc & ALIGN_MASK;

`ifdef IF_PREDICT_EN
  logic [31:0] rd;
  logic [31:0] j_imm;
  logic [31:0] b_imm;
  assign rd    = icache.rdata;
  assign j_imm = {{12{rd[31]}}, rd[19:12], rd[20], rd[30:21], 1'b0};
  assign b_imm = {{20{rd[31]}}, rd[7], rd[30:25], rd[11:8], 1'b0};

  // Predict JAL always taken, conditional branches taken only when backward.
  always_comb begin
    next_pc    = pc_reg + 32'd4;
    pred_taken = 1'b0;
    if (rd[6:2] == 5'b11011) begin
      next_pc    = pc_reg + j_imm;
      pred_taken = 1'b1;
    end else if ((rd[6:2] == 5'b11000) && rd[31]) begin
      next_pc    = pc_reg + b_imm;
      pred_taken = 1'b1;
    end
  end
`else
  assign next_pc    = pc_reg + 32'd4;
  assign pred_taken = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    id_valid_next  = id_valid_reg;
    id_inst_next   = id_inst_reg;
    id_pc_next     = id_pc_reg;
    id_pred_next   = id_pred_reg;
    skid_inst_next = skid_inst_reg;
    skid_pc_next   = skid_pc_reg;
    skid_pred_next = skid_pred_reg;
    kill_next      = kill_reg;
    kill_pc_next   = kill_pc_reg;

    ren        = ((state_reg == S_FETCH) && !(id_valid_reg && id_stall)) || (state_reg == S_WAIT);
    complete   = ren && !icache.stall;
    can_accept = !id_valid_reg || !id_stall;

    if (id_valid_reg && !id_stall)
      id_valid_next = 1'b0;

    if (redirect_valid) begin
      id_valid_next = 1'b0;
      // A stalled request must keep its address, so the target waits in kill_pc.
      if (ren && icache.stall) begin
        kill_next    = 1'b1;
        kill_pc_next = redirect_target;
        state_next   = S_WAIT;
      end else begin
        pc_next    = redirect_target;
        kill_next  = 1'b0;
        state_next = S_FETCH;
      end
    end else begin
      case (state_reg)
        S_IDLE: state_next = S_FETCH;
        S_FETCH, S_WAIT: begin
          if (ren && icache.stall) begin
            state_next = S_WAIT;
          end else if (complete) begin
            state_next = S_FETCH;
            if (kill_reg) begin
              pc_next   = kill_pc_reg;
              kill_next = 1'b0;
            end else if (can_accept) begin
              id_valid_next = 1'b1;
              id_inst_next  = icache.rdata;
              id_pc_next    = pc_reg;
              id_pred_next  = pred_taken;
              pc_next       = next_pc;
            end else begin
              skid_inst_next = icache.rdata;
              skid_pc_next   = pc_reg;
              skid_pred_next = pred_taken;
              pc_next        = next_pc;
              state_next     = S_SKID;
            end
          end
        end
        S_SKID: begin
          if (!id_stall) begin
            id_valid_next = 1'b1;
            id_inst_next  = skid_inst_reg;
            id_pc_next    = skid_pc_reg;
            id_pred_next  = skid_pred_reg;
            state_next    = S_FETCH;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      pc_reg        <= RESET_PC & ALIGN_MASK;
      id_valid_reg  <= 1'b0;
      id_inst_reg   <= NOP;
      id_pc_reg     <= 32'd0;
      id_pred_reg   <= 1'b0;
      skid_inst_reg <= NOP;
      skid_pc_reg   <= 32'd0;
      skid_pred_reg <= 1'b0;
      kill_reg      <= 1'b0;
      kill_pc_reg   <= 32'd0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      id_valid_reg  <= id_valid_next;
      id_inst_reg   <= id_inst_next;
      id_pc_reg     <= id_pc_next;
      id_pred_reg   <= id_pred_next;
      skid_inst_reg <= skid_inst_next;
      skid_pc_reg   <= skid_pc_next;
      skid_pred_reg <= skid_pred_next;
      kill_reg      <= kill_next;
      kill_pc_reg   <= kill_pc_next;
    end
  end

  assign icache.ren    = ren;
  assign icache.addr   = pc_reg[31:2];
  assign id_valid      = id_valid_reg;
  assign id_inst       = id_valid_reg ? id_inst_reg : NOP;
  assign id_pc         = id_pc_reg;
  assign id_pred_taken = id_valid_reg & id_pred_reg;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed, table-driven bench for inst_fetch: one table row per clock cycle,
// plus a hand-written reset-during-miss sequence.
module tb_inst_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_PREDICT_EN
  localparam logic [31:0] P_ADDR1 = 32'h0000_007C;
  localparam logic [31:0] P_ADDR2 = 32'h0000_0080;
  localparam logic        P_TAKEN = 1'b1;
`else
  localparam logic [31:0] P_ADDR1 = 32'h0000_0084;
  localparam logic [31:0] P_ADDR2 = 32'h0000_0088;
  localparam logic        P_TAKEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_pred_taken;
  logic        cache_stall = 1'b0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  inst_fetch_if bus ();

  function automatic logic [31:0] img(input logic [31:0] a);
    if (a == 32'h0000_0080) return 32'hFE00_0EE3;
    return (a << 5) | 32'h13;
  endfunction

  assign bus.rdata = img({bus.addr, 2'b00});
  assign bus.stall = cache_stall;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .icache         (bus.master),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_pred_taken  (id_pred_taken)
  );

  typedef struct {
    logic        ids;
    logic        rv;
    logic [31:0] rpc;
    logic        st;
    logic        e_ren;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
    logic        e_pred;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ids, input logic rv, input logic [31:0] rpc, input logic st,
                     input logic e_ren, input logic [31:0] e_addr, input logic e_v,
                     input logic [31:0] e_pc, input logic e_pred);
    vec_t t;
    t.ids = ids; t.rv = rv; t.rpc = rpc; t.st = st;
    t.e_ren = e_ren; t.e_addr = e_addr; t.e_v = e_v; t.e_pc = e_pc; t.e_pred = e_pred;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic ok, input string got, input string want);
    checks++;
    if (ok) begin
      passed++;
      $display("%s ok: %s", name, got);
    end else begin
      $display("FAIL %s: got %s, want %s", name, got, want);
    end
  endtask

  initial begin
    // Cycle-by-cycle stimulus and expectations; cycle 0 is the first cycle after reset release.
    //   ids rv rpc            st  ren addr           v  id_pc          pred
    add(0, 0, 32'h0,         0,  0,  32'h0,         0, 32'h0,         0); // c0 IDLE
    add(0, 0, 32'h0,         0,  1,  32'h0,         0, 32'h0,         0); // c1 first request
    add(0, 0, 32'h0,         0,  1,  32'h4,         1, 32'h0,         0);
    add(0, 0, 32'h0,         0,  1,  32'h8,         1, 32'h4,         0);
    add(0, 0, 32'h0,         0,  1,  32'hC,         1, 32'h8,         0);
    add(0, 0, 32'h0,         1,  1,  32'h10,        1, 32'hC,         0); // c5 miss on 0x10
    add(0, 0, 32'h0,         1,  1,  32'h10,        0, 32'h0,         0);
    add(0, 0, 32'h0,         1,  1,  32'h10,        0, 32'h0,         0);
    add(0, 0, 32'h0,         1,  1,  32'h10,        0, 32'h0,         0);
    add(0, 0, 32'h0,         1,  1,  32'h10,        0, 32'h0,         0);
    add(0, 0, 32'h0,         0,  1,  32'h10,        0, 32'h0,         0); // c10 miss completes
    add(0, 0, 32'h0,         1,  1,  32'h14,        1, 32'h10,        0); // c11 miss on 0x14
    add(1, 0, 32'h0,         1,  1,  32'h14,        0, 32'h0,         0); // decode stall while waiting
    add(1, 0, 32'h0,         0,  1,  32'h14,        0, 32'h0,         0);
    add(1, 0, 32'h0,         0,  0,  32'h0,         1, 32'h14,        0); // held, no new request
    add(1, 0, 32'h0,         0,  0,  32'h0,         1, 32'h14,        0);
    add(0, 0, 32'h0,         0,  1,  32'h18,        1, 32'h14,        0);
    add(0, 1, 32'h40,        0,  1,  32'h1C,        1, 32'h18,        0); // c17 redirect on a hit
    add(0, 0, 32'h0,         1,  1,  32'h40,        0, 32'h0,         0); // c18 miss on 0x40
    add(0, 1, 32'h200,       1,  1,  32'h40,        0, 32'h0,         0); // redirect mid-miss
    add(0, 0, 32'h0,         1,  1,  32'h40,        0, 32'h0,         0);
    add(0, 0, 32'h0,         0,  1,  32'h40,        0, 32'h0,         0); // killed completion
    add(0, 0, 32'h0,         0,  1,  32'h200,       0, 32'h0,         0);
    add(1, 1, 32'h103,       0,  0,  32'h0,         1, 32'h200,       0); // c23 redirect with decode stall
    add(0, 0, 32'h0,         0,  1,  32'h100,       0, 32'h0,         0);
    add(0, 1, 32'h80,        0,  1,  32'h104,       1, 32'h100,       0); // c25 redirect to branch
    add(0, 0, 32'h0,         0,  1,  32'h80,        0, 32'h0,         0);
    add(0, 0, 32'h0,         0,  1,  P_ADDR1,       1, 32'h80,        P_TAKEN);
    add(0, 1, 32'hFFFF_FFF8, 0,  1,  P_ADDR2,       1, P_ADDR1,       0); // c28 redirect near top
    add(0, 0, 32'h0,         0,  1,  32'hFFFF_FFF8, 0, 32'h0,         0);
    add(0, 0, 32'h0,         0,  1,  32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 0);
    add(0, 0, 32'h0,         0,  1,  32'h0,         1, 32'hFFFF_FFFC, 0); // pc wrapped
    add(0, 0, 32'h0,         0,  1,  32'h4,         1, 32'h0,         0);

    // Reset state while rst_n is low.
    @(negedge clk);
    check("reset", (bus.ren == 1'b0) && !id_valid && (id_inst == NOP) && (id_pc == 32'd0) && !id_pred_taken,
          $sformatf("ren=%0b v=%0b inst=%h pc=%h pred=%0b", bus.ren, id_valid, id_inst, id_pc, id_pred_taken),
          "ren=0 v=0 inst=00000013 pc=00000000 pred=0");
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      logic        ok;
      logic [31:0] e_inst;
      id_stall       = vecs[i].ids;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      cache_stall    = vecs[i].st;
      e_inst = vecs[i].e_v ? img(vecs[i].e_pc) : NOP;
      @(negedge clk);
      ok = (bus.ren == vecs[i].e_ren) &&
           (!vecs[i].e_ren || (bus.addr == vecs[i].e_addr[31:2])) &&
           (id_valid == vecs[i].e_v) &&
           (!vecs[i].e_v || (id_pc == vecs[i].e_pc)) &&
           (id_inst == e_inst) &&
           (id_pred_taken == vecs[i].e_pred);
      check($sformatf("cycle%0d", i), ok,
            $sformatf("ren=%0b addr=%h v=%0b pc=%h inst=%h pred=%0b",
                      bus.ren, {bus.addr, 2'b00}, id_valid, id_pc, id_inst, id_pred_taken),
            $sformatf("ren=%0b addr=%h v=%0b pc=%h inst=%h pred=%0b",
                      vecs[i].e_ren, vecs[i].e_addr, vecs[i].e_v, vecs[i].e_pc, e_inst, vecs[i].e_pred));
      @(posedge clk);
      #1;
    end

    // Reset asserted in the middle of a miss abandons the request at once.
    id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    cache_stall = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("reset_mid_miss", (bus.ren == 1'b0) && !id_valid && (id_inst == NOP),
          $sformatf("ren=%0b v=%0b inst=%h", bus.ren, id_valid, id_inst), "ren=0 v=0 inst=00000013");
    cache_stall = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", (bus.ren == 1'b0) && !id_valid,
          $sformatf("ren=%0b v=%0b", bus.ren, id_valid), "ren=0 v=0");
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_reset_fetch", (bus.ren == 1'b1) && (bus.addr == 30'd0) && !id_valid,
          $sformatf("ren=%0b addr=%h v=%0b", bus.ren, {bus.addr, 2'b00}, id_valid), "ren=1 addr=00000000 v=0");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
